// File: rtl/eq_fifo_pkg.sv
// Shared types and default widths for the equaliser FIFO writer/reader pair.
package eq_fifo_pkg;

  localparam int unsigned DROP_CNT_W     = 16;
  localparam int unsigned EQ_D_WIDTH     = 24;
  localparam int unsigned EQ_USEDW_WIDTH = 3;
  localparam int unsigned EQ_HOLD_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    STALL  = 2'd2
  } wr_state_e;

  // Pointer width for a circular buffer; never below one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_writer_hold.sv
// Small circular holding buffer: read/write pointers plus an occupancy count.
module fifo_writer_hold
  import eq_fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = EQ_D_WIDTH,
  parameter int unsigned DEPTH   = EQ_HOLD_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [D_WIDTH-1:0]        i_wdata,
  output logic [D_WIDTH-1:0]        o_rdata_c,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full_c,
  output logic                      o_empty_c
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push+pop together leaves count as is.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sample storage; contents are don't-care while count says empty.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rptr];
  assign o_count   = r_count;
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);

endmodule

// File: rtl/fifo_writer.sv
// Buffers incoming samples and issues registered writes into a downstream FIFO
// without ever overfilling it. Optional macro FIFO_WRITER_DROP_CNT_EN builds a
// 16-bit saturating dropped-sample counter; otherwise drop_cnt_o is zero.
module fifo_writer
  import eq_fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH     = EQ_D_WIDTH,
  parameter int unsigned USEDW_WIDTH = EQ_USEDW_WIDTH,
  parameter int unsigned HOLD_DEPTH  = EQ_HOLD_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   ena_i,
  output logic                   ready_o,
  input  logic                   full_i,
  input  logic [USEDW_WIDTH-1:0] usedw_i,
  output logic                   wrreq_o,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   ovf_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

  localparam int unsigned CNT_W = cnt_w(HOLD_DEPTH);

  wr_state_e          r_state;
  wr_state_e          w_state_nxt;
  logic               r_wrreq;
  logic               r_ovf;
  logic [D_WIDTH-1:0] r_data;

  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_issue_ok;
  logic               w_fifo_last;
  logic               w_full;
  logic               w_empty;
  logic               w_last_out;
  logic [CNT_W-1:0]   w_count;
  logic [D_WIDTH-1:0] w_head;

  // A write in flight may be filling the last free slot; usedw_i has not seen it yet.
  assign w_fifo_last = r_wrreq & (usedw_i == {USEDW_WIDTH{1'b1}});
  assign w_issue_ok  = ~full_i & ~w_fifo_last;

  assign ready_o = ~w_full | w_pop;
  assign w_push  = ena_i & ready_o;
  assign w_drop  = ena_i & ~ready_o;

  fifo_writer_hold #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (HOLD_DEPTH)
  ) u_hold (
    .i_clk     (clk_i),
    .i_rst_n   (nrst_i),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (data_i),
    .o_rdata_c (w_head),
    .o_count   (w_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // FSM state register; IDLE tracks an empty holding buffer exactly.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state from next-cycle occupancy and the current issue permission.
  always_comb begin
    w_state_nxt = r_state;
    w_last_out  = w_pop & ~w_push & (w_count == CNT_W'(1));
    if ((w_empty & ~w_push) | w_last_out) w_state_nxt = IDLE;
    else if (w_issue_ok)                  w_state_nxt = STREAM;
    else                                  w_state_nxt = STALL;
  end

  // Pop whenever something is held and the FIFO can take a write.
  always_comb begin
    w_pop = 1'b0;
    if (r_state != IDLE) w_pop = w_issue_ok;
  end

  // Registered FIFO write port and sticky overflow flag.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_wrreq <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wrreq <= w_pop;
      if (w_pop)  r_data <= w_head;
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

`ifdef FIFO_WRITER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Saturating count of samples refused while the buffer was full.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)                            r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1))  r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
  end

  assign drop_cnt_o = r_drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

  assign wrreq_o = r_wrreq;
  assign data_o  = r_data;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_fifo_writer.sv
// Directed bench for fifo_writer: a queue holds the samples expected on the
// FIFO write port, a negedge monitor checks every write against it.
module tb_fifo_writer;

  logic        clk = 1'b0;
  logic        nrst_i = 1'b1;
  logic [23:0] data_i = '0;
  logic        ena_i = 1'b0;
  logic        ready_o;
  logic        full_i = 1'b0;
  logic [2:0]  usedw_i = '0;
  logic        wrreq_o;
  logic [23:0] data_o;
  logic        ovf_o;
  logic [15:0] drop_cnt_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [23:0] sb[$];

  fifo_writer dut (
    .clk_i      (clk),
    .nrst_i     (nrst_i),
    .data_i     (data_i),
    .ena_i      (ena_i),
    .ready_o    (ready_o),
    .full_i     (full_i),
    .usedw_i    (usedw_i),
    .wrreq_o    (wrreq_o),
    .data_o     (data_o),
    .ovf_o      (ovf_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every FIFO write must match the oldest expected sample.
  always @(negedge clk) begin
    if (nrst_i === 1'b1 && wrreq_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got data 0x%0h, expected no write at %0t", data_o, $time);
      end else begin
        chk("write_data", 32'(data_o), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_drop;
`ifdef FIFO_WRITER_DROP_CNT_EN
    exp_drop = 16'd2;
`else
    exp_drop = 16'd0;
`endif

    // Reset state
    #1 nrst_i = 1'b0;
    #3;
    chk("rst_wrreq", 32'(wrreq_o), 32'd0);
    chk("rst_data",  32'(data_o), 32'd0);
    chk("rst_ovf",   32'(ovf_o), 32'd0);
    chk("rst_drop",  32'(drop_cnt_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    #3 nrst_i = 1'b1;
    tick();

    // Single sample: write appears two cycles after acceptance, once
    data_i = 24'h000123; ena_i = 1'b1;
    sb.push_back(24'h000123);
    chk("single_ready", 32'(ready_o), 32'd1);
    tick();
    ena_i = 1'b0;
    chk("single_c1", 32'(wrreq_o), 32'd0);
    tick();
    chk("single_c2", 32'(wrreq_o), 32'd1);
    chk("single_d2", 32'(data_o), 32'h123);
    tick();
    chk("single_c3", 32'(wrreq_o), 32'd0);
    tick();

    // Continuous stream 1..10
    for (int i = 1; i <= 10; i++) begin
      data_i = 24'(i); ena_i = 1'b1;
      sb.push_back(24'(i));
      chk("stream_ready", 32'(ready_o), 32'd1);
      tick();
      if (i >= 2) chk("stream_wrreq", 32'(wrreq_o), 32'd1);
    end
    ena_i = 1'b0;
    tick();
    chk("stream_last", 32'(wrreq_o), 32'd1);
    tick();
    chk("stream_end", 32'(wrreq_o), 32'd0);
    chk("stream_ovf", 32'(ovf_o), 32'd0);
    tick();

    // FIFO full: two held, two dropped
    full_i = 1'b1; usedw_i = 3'd0;
    sb.push_back(24'hA);
    sb.push_back(24'hB);
    for (int i = 0; i < 4; i++) begin
      data_i = 24'(24'hA + i); ena_i = 1'b1;
      chk("full_ready", 32'(ready_o), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    ena_i = 1'b0;
    chk("full_ovf",  32'(ovf_o), 32'd1);
    chk("full_drop", 32'(drop_cnt_o), 32'(exp_drop));
    tick();
    chk("full_nowr", 32'(wrreq_o), 32'd0);
    full_i = 1'b0;
    tick();
    chk("full_wr_a", 32'(wrreq_o), 32'd1);
    tick();
    chk("full_wr_b", 32'(wrreq_o), 32'd1);
    tick();
    chk("full_done", 32'(wrreq_o), 32'd0);
    chk("full_ovf_sticky", 32'(ovf_o), 32'd1);

    // Last free FIFO slot being filled: hold off until usedw/full catch up
    usedw_i = 3'd6;
    data_i = 24'h51; ena_i = 1'b1; sb.push_back(24'h51);
    tick();
    data_i = 24'h52; sb.push_back(24'h52);
    tick();
    ena_i = 1'b0;
    usedw_i = 3'd7;
    chk("bnd_wr", 32'(wrreq_o), 32'd1);
    tick();
    chk("bnd_hold", 32'(wrreq_o), 32'd0);
    full_i = 1'b1; usedw_i = 3'd0;
    tick();
    chk("bnd_full", 32'(wrreq_o), 32'd0);
    full_i = 1'b0; usedw_i = 3'd6;
    tick();
    chk("bnd_resume", 32'(wrreq_o), 32'd1);
    usedw_i = 3'd0;
    tick();
    chk("bnd_done", 32'(wrreq_o), 32'd0);

    // Reset with two held samples: they must never be written
    full_i = 1'b1;
    data_i = 24'h61; ena_i = 1'b1;
    tick();
    data_i = 24'h62;
    tick();
    ena_i = 1'b0;
    chk("pre_rst_ready", 32'(ready_o), 32'd0);
    #2 nrst_i = 1'b0;
    #1;
    chk("arst_wrreq", 32'(wrreq_o), 32'd0);
    chk("arst_data",  32'(data_o), 32'd0);
    chk("arst_ovf",   32'(ovf_o), 32'd0);
    chk("arst_drop",  32'(drop_cnt_o), 32'd0);
    #2 nrst_i = 1'b1;
    full_i = 1'b0;
    tick();
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_wrreq", 32'(wrreq_o), 32'd0);
    data_i = 24'h71; ena_i = 1'b1; sb.push_back(24'h71);
    tick();
    ena_i = 1'b0;
    chk("post_rst_c1", 32'(wrreq_o), 32'd0);
    tick();
    chk("post_rst_c2", 32'(wrreq_o), 32'd1);
    tick();
    chk("post_rst_c3", 32'(wrreq_o), 32'd0);
    tick();
    tick();

    // Everything expected must have been written
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
